// File: rtl/muon_pkg.sv
// Shared types and default timing constants for the muon-lifetime sequencer.
package muon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VETO   = 2'd1,
    WAIT   = 2'd2,
    REPORT = 2'd3
  } muon_state_t;

  localparam int DEFAULT_WINDOW_CYCLES   = 2000;
  localparam int DEFAULT_DEADTIME_CYCLES = 10;
  localparam int DEFAULT_TIME_W          = 16;
  localparam int DEFAULT_CNT_W           = 32;

endpackage

// File: rtl/rising_edge_detect.sv
// Single-cycle pulse on each low-to-high transition of a level input.
module rising_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/muon_decay_sequencer.sv
// Times the gap between a muon-stop coincidence and the decay-electron coincidence,
// hands the result to readout over valid/ready and keeps saturating event counters.
module muon_decay_sequencer
  import muon_pkg::*;
#(
  parameter int WINDOW_CYCLES   = DEFAULT_WINDOW_CYCLES,
  parameter int DEADTIME_CYCLES = DEFAULT_DEADTIME_CYCLES,
  parameter int TIME_W          = DEFAULT_TIME_W,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              coincidence,
  input  logic              out_ready,
  output logic              lifetime_valid,
  output logic [TIME_W-1:0] lifetime_cycles,
  output logic              busy,
  output logic [CNT_W-1:0]  start_count,
  output logic [CNT_W-1:0]  decay_count,
  output logic [CNT_W-1:0]  timeout_count
);

  localparam logic [TIME_W-1:0] VETO_LAST   = TIME_W'(DEADTIME_CYCLES - 1);
  localparam logic [TIME_W-1:0] WINDOW_LAST = TIME_W'(WINDOW_CYCLES - 1);

  muon_state_t       state, state_next;
  logic [TIME_W-1:0] timer, timer_next;
  logic [TIME_W-1:0] lifetime_q, lifetime_next;
  logic [CNT_W-1:0]  start_q, decay_q, timeout_q;
  logic              start_hit, decay_hit, timeout_hit;
  logic              coinc_edge;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  rising_edge_detect u_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (coincidence),
    .pulse (coinc_edge)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      lifetime_q <= '0;
      start_q    <= '0;
      decay_q    <= '0;
      timeout_q  <= '0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      lifetime_q <= lifetime_next;
      if (start_hit)   start_q   <= sat_inc(start_q);
      if (decay_hit)   decay_q   <= sat_inc(decay_q);
      if (timeout_hit) timeout_q <= sat_inc(timeout_q);
    end
  end

  // Dropping enable abandons a running timer, but a captured lifetime is still delivered.
  always_comb begin
    state_next    = state;
    timer_next    = timer;
    lifetime_next = lifetime_q;
    start_hit     = 1'b0;
    decay_hit     = 1'b0;
    timeout_hit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && coinc_edge) begin
          state_next = VETO;
          timer_next = TIME_W'(1);
          start_hit  = 1'b1;
        end
      end
      VETO: begin
        if (!enable) begin
          state_next = IDLE;
          timer_next = '0;
        end else begin
          timer_next = timer + TIME_W'(1);
          if (timer == VETO_LAST) state_next = WAIT;
        end
      end
      WAIT: begin
        if (!enable) begin
          state_next = IDLE;
          timer_next = '0;
        end else if (coinc_edge) begin
          lifetime_next = timer;
          state_next    = REPORT;
        end else if (timer == WINDOW_LAST) begin
          state_next  = IDLE;
          timer_next  = '0;
          timeout_hit = 1'b1;
        end else begin
          timer_next = timer + TIME_W'(1);
        end
      end
      REPORT: begin
        if (out_ready) begin
          decay_hit  = 1'b1;
          state_next = IDLE;
          timer_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  assign lifetime_valid  = (state == REPORT);
  assign busy            = (state != IDLE);
  assign lifetime_cycles = lifetime_q;
  assign start_count     = start_q;
  assign decay_count     = decay_q;
  assign timeout_count   = timeout_q;

endmodule

// File: tb/tb_muon_decay_sequencer.sv
// Scenario bench for muon_decay_sequencer with a lifetime scoreboard checked at each handshake.
module tb_muon_decay_sequencer;

  localparam int WIN    = 100;
  localparam int DEAD   = 4;
  localparam int TIME_W = 16;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              coincidence;
  logic              out_ready;
  logic              lifetime_valid;
  logic [TIME_W-1:0] lifetime_cycles;
  logic              busy;
  logic [CNT_W-1:0]  start_count;
  logic [CNT_W-1:0]  decay_count;
  logic [CNT_W-1:0]  timeout_count;

  int checks   = 0;
  int failures = 0;
  int exp_start   = 0;
  int exp_decay   = 0;
  int exp_timeout = 0;
  logic [TIME_W-1:0] sb[$];

  muon_decay_sequencer #(
    .WINDOW_CYCLES  (WIN),
    .DEADTIME_CYCLES(DEAD),
    .TIME_W         (TIME_W),
    .CNT_W          (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .coincidence    (coincidence),
    .out_ready      (out_ready),
    .lifetime_valid (lifetime_valid),
    .lifetime_cycles(lifetime_cycles),
    .busy           (busy),
    .start_count    (start_count),
    .decay_count    (decay_count),
    .timeout_count  (timeout_count)
  );

  always #5 clk = ~clk;

  // Every accepted handshake must match the oldest expected lifetime.
  always @(negedge clk) begin
    if (!rst && lifetime_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL sb_unexpected: got lifetime %0d, none expected", lifetime_cycles);
      end else begin
        logic [TIME_W-1:0] exp_lt;
        exp_lt = sb.pop_front();
        if (lifetime_cycles !== exp_lt) begin
          failures++;
          $display("[TB] FAIL sb_lifetime: got %0d expected %0d", lifetime_cycles, exp_lt);
        end
      end
    end
  end

  task automatic drive_cycle(input logic c);
    coincidence = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    checks++;
    if (start_count !== CNT_W'(exp_start) || decay_count !== CNT_W'(exp_decay) ||
        timeout_count !== CNT_W'(exp_timeout)) begin
      failures++;
      $display("[TB] FAIL %s_counters: got s=%0d d=%0d t=%0d expected s=%0d d=%0d t=%0d",
               tag, start_count, decay_count, timeout_count, exp_start, exp_decay, exp_timeout);
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (busy !== 1'b0 || lifetime_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_idle: got busy=%b valid=%b expected 0 0", tag, busy, lifetime_valid);
    end
  endtask

  // Edges at cycle 0 and cycle stop; leaves the bench in cycle stop+1.
  task automatic run_pair(input int stop);
    for (int i = 0; i <= stop; i++) drive_cycle(i == 0 || i == stop);
  endtask

  task automatic check_report(input string tag, input int lt);
    checks++;
    if (lifetime_valid !== 1'b1 || lifetime_cycles !== TIME_W'(lt)) begin
      failures++;
      $display("[TB] FAIL %s_report: got valid=%b lifetime=%0d expected 1 %0d",
               tag, lifetime_valid, lifetime_cycles, lt);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b1; coincidence = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset");
    checks++;
    if (lifetime_cycles !== '0) begin
      failures++;
      $display("[TB] FAIL reset_lifetime: got %0d expected 0", lifetime_cycles);
    end
    check_counters("reset");
  endtask

  task automatic test_normal_decay;
    drive_cycle(1'b1);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL decay_busy_rise: got %b expected 1", busy);
    end
    for (int i = 1; i <= 37; i++) begin
      if (i == 37) sb.push_back(TIME_W'(37));
      drive_cycle(i == 37);
    end
    exp_start++;
    check_report("decay", 37);
    drive_cycle(1'b0);
    exp_decay++;
    check_idle("decay");
    check_counters("decay");
  endtask

  task automatic test_veto;
    sb.push_back(TIME_W'(50));
    for (int i = 0; i <= 50; i++) drive_cycle(i == 0 || i == 2 || i == 50);
    exp_start++;
    check_report("veto", 50);
    drive_cycle(1'b0);
    exp_decay++;
    check_counters("veto");
  endtask

  task automatic test_min_lifetime;
    sb.push_back(TIME_W'(DEAD));
    run_pair(DEAD);
    exp_start++;
    check_report("min_lifetime", DEAD);
    drive_cycle(1'b0);
    exp_decay++;
    check_counters("min_lifetime");
  endtask

  task automatic test_timeout;
    for (int i = 0; i < WIN; i++) begin
      drive_cycle(i == 0);
      if (i == WIN - 2) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("[TB] FAIL timeout_early: got busy=%b at cycle %0d expected 1", busy, WIN - 1);
        end
      end
    end
    exp_start++;
    exp_timeout++;
    check_idle("timeout");
    check_counters("timeout");
  endtask

  task automatic test_window_boundary;
    sb.push_back(TIME_W'(WIN - 1));
    run_pair(WIN - 1);
    exp_start++;
    check_report("boundary", WIN - 1);
    drive_cycle(1'b0);
    exp_decay++;
    check_counters("boundary");
  endtask

  task automatic test_backpressure;
    int bad;
    bad = 0;
    sb.push_back(TIME_W'(10));
    run_pair(10);
    out_ready = 1'b0;
    exp_start++;
    for (int i = 0; i < 20; i++) begin
      if (lifetime_valid !== 1'b1 || lifetime_cycles !== TIME_W'(10)) bad++;
      drive_cycle(i == 5);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL stall_hold: %0d stall cycles lost valid or lifetime, expected 0", bad);
    end
    check_report("stall", 10);
    check_counters("stall");
    out_ready = 1'b1;
    drive_cycle(1'b0);
    exp_decay++;
    check_idle("stall_release");
    check_counters("stall_release");
  endtask

  task automatic test_back_to_back;
    sb.push_back(TIME_W'(10));
    sb.push_back(TIME_W'(6));
    run_pair(10);
    drive_cycle(1'b0);
    run_pair(6);
    exp_start += 2;
    check_report("b2b", 6);
    drive_cycle(1'b0);
    exp_decay += 2;
    check_counters("b2b");
  endtask

  task automatic test_abort;
    for (int i = 0; i < 30; i++) drive_cycle(i == 0);
    enable = 1'b0;
    drive_cycle(1'b0);
    exp_start++;
    check_idle("abort");
    check_counters("abort");
    for (int i = 0; i < 5; i++) drive_cycle(i == 2);
    check_idle("enable_low_edge");
    enable = 1'b1;
    repeat (WIN) drive_cycle(1'b0);
    check_counters("abort_late");
  endtask

  task automatic test_reset_in_report;
    out_ready = 1'b0;
    run_pair(20);
    check_report("rst_report", 20);
    rst = 1'b1;
    drive_cycle(1'b0);
    rst = 1'b0;
    out_ready = 1'b1;
    exp_start = 0; exp_decay = 0; exp_timeout = 0;
    check_idle("rst_report");
    checks++;
    if (lifetime_cycles !== '0) begin
      failures++;
      $display("[TB] FAIL rst_report_lifetime: got %0d expected 0", lifetime_cycles);
    end
    check_counters("rst_report");
  endtask

  task automatic test_level_input;
    int valid_seen;
    valid_seen = 0;
    for (int i = 0; i <= WIN + 2; i++) begin
      drive_cycle(i < 50);
      if (lifetime_valid) valid_seen++;
    end
    exp_start++;
    exp_timeout++;
    checks++;
    if (valid_seen != 0) begin
      failures++;
      $display("[TB] FAIL level_valid: got %0d valid cycles expected 0", valid_seen);
    end
    check_counters("level");
  endtask

  initial begin
    test_reset();
    test_normal_decay();
    test_veto();
    test_min_lifetime();
    test_timeout();
    test_window_boundary();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_reset_in_report();
    test_level_input();
    repeat (3) drive_cycle(1'b0);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL sb_leftover: got %0d undelivered lifetimes expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/muon_decay_sequencer.md
# muon_decay_sequencer

Sequences the muon-lifetime measurement downstream of the coincidence detector. A first coincidence pulse (muon stop) starts a decay timer. A second coincidence pulse inside the measurement window (decay electron) stops it. The elapsed cycle count is then presented on a valid/ready output to the readout logic. The block also keeps running counts of started, completed and timed-out events for rate monitoring.

## Interface
Parameters:
- WINDOW_CYCLES, 2000: measurement window in clk cycles (20 µs at 100 MHz); must be > DEADTIME_CYCLES.
- DEADTIME_CYCLES, 10: veto after the start edge; stop edges are ignored while the timer is below this.
- TIME_W, 16: width of lifetime_cycles; must hold WINDOW_CYCLES-1.
- CNT_W, 32: width of the statistics counters.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  arms the sequencer; low aborts any measurement in progress.
- coincidence  in  1  output of the coincidence detector; level, edge-detected internally.
- out_ready  in  1  readout accepts the lifetime word.
- lifetime_valid  out  1  lifetime word available.
- lifetime_cycles  out  TIME_W  start-to-stop edge distance in cycles.
- busy  out  1  high in every state except IDLE.
- start_count  out  CNT_W  measurements started.
- decay_count  out  CNT_W  lifetimes accepted by readout.
- timeout_count  out  CNT_W  windows that expired without a stop.

## Operation
- Edge detect: register coincidence; edge = coincidence & ~coincidence_q. Only edges act; a held-high level is one event.
- States: IDLE, VETO, WAIT, REPORT.
- IDLE: on edge with enable=1, go to VETO, timer <= 1, start_count += 1.
- VETO: timer += 1 each cycle; edges ignored; at timer == DEADTIME_CYCLES-1, go to WAIT.
- WAIT:
  - On edge: lifetime_cycles <= timer, go to REPORT.
  - Else if timer == WINDOW_CYCLES-1: go to IDLE, timeout_count += 1.
  - Else timer += 1.
- REPORT: lifetime_valid=1 and lifetime_cycles held stable until out_ready. On the valid&ready cycle, decay_count += 1 and go to IDLE. Edges during REPORT are ignored.
- enable=0 in VETO or WAIT: abort to IDLE next cycle with no counter change.
- enable=0 in REPORT: the pending word is still delivered.
- Counters saturate at all-ones and do not wrap.
- Accepted lifetime range: DEADTIME_CYCLES ≤ lifetime_cycles ≤ WINDOW_CYCLES-1.

## Timing
- Reset: state=IDLE, timer=0, lifetime_valid=0, lifetime_cycles=0, busy=0, all counters=0. rst overrides enable and out_ready.
- rst mid-measurement or mid-REPORT: the word is discarded with no handshake.
- Define cycle 0 as the cycle the start edge is sampled. A stop edge sampled at cycle N gives lifetime_cycles=N, with lifetime_valid high from cycle N+1.
- busy rises at cycle 1.
- A start edge sampled at cycle 0 with out_ready held high returns to IDLE at cycle N+2. The next start edge is accepted from cycle N+2.
- With no stop edge, the timeout is taken at cycle WINDOW_CYCLES-1, and the block is back in IDLE at cycle WINDOW_CYCLES.
- A stop edge at exactly WINDOW_CYCLES-1 is a decay, not a timeout: the edge has priority.
- Start and stop in consecutive cycles is impossible, because the edge detector needs coincidence to fall first.

## Structure
- Package muon_pkg: state enum (IDLE, VETO, WAIT, REPORT) and default constants for WINDOW_CYCLES and DEADTIME_CYCLES.
- Sub-module rising_edge_detect (clk, rst, d, edge), reusable by other front-end blocks.
- Counters are inline with a saturating increment.

## Test plan
Bench parameters: WINDOW_CYCLES=100, DEADTIME_CYCLES=4, 100 MHz clock, out_ready=1 unless stated.
- Normal decay: edge at cycle 0, edge at cycle 37 -> lifetime_valid at cycle 38 with lifetime_cycles=37; start_count=1, decay_count=1.
- Veto: edges at cycles 0, 2 and 50 -> a single lifetime of 50; the edge at cycle 2 is ignored.
- Timeout: edge at cycle 0, none after -> IDLE at cycle 100 with timeout_count=1 and no valid. Boundary repeat: stop edge at cycle 99 -> lifetime_cycles=99, timeout_count unchanged.
- Backpressure: out_ready=0 for 20 cycles after the stop at cycle 10 -> valid held with lifetime_cycles stable at 10; an extra edge during the stall is ignored; decay_count increments once, on the handshake cycle.
- Abort/reset: enable dropped at cycle 30 of WAIT -> IDLE with no counter change. rst asserted during REPORT -> all outputs and counters zero the next cycle.
- Level input: coincidence held high for 50 cycles -> exactly one start, then timeout_count=1.
